mod_exp: RTL and testbench

- Sequential modular exponentiator for the RSA-style public-key decryption path: computes msgOut = msgIn^key mod n.
- Uses right-to-left binary square-and-multiply.
- Each modular product comes from an iterative shift-add modular multiplier.
- Sits between the ciphertext source and the plaintext consumer; start/fins is a level handshake.

---
 rtl/mod_exp_pkg.sv | 23 ++
 rtl/mod_exp_if.sv | 32 +++
 rtl/mod_mult.sv | 80 ++++++++
 rtl/mod_exp.sv | 149 ++++++++++++++
 tb/tb_mod_exp.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mod_exp_pkg.sv
// ============================================================================
// mod_exp_pkg : shared constants and FSM state encoding for mod_exp
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mod_exp_pkg;

   localparam int KEY_W_DEFAULT = 24;
   localparam int MSG_W_DEFAULT = 12;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REDUCE = 3'd1,
      CHECK  = 3'd2,
      MUL    = 3'd3,
      SQR    = 3'd4,
      DONE   = 3'd5
   } state_t;

endpackage

`default_nettype wire

// File: rtl/mod_exp_if.sv
// ============================================================================
// mod_exp_if : request/result bundle of mod_exp (err only with MOD_EXP_ERR_EN)
// Revision   : 1.0
// ============================================================================
`default_nettype none

interface mod_exp_if
   import mod_exp_pkg::*;
#(
   parameter int KEY_W = KEY_W_DEFAULT,
   parameter int MSG_W = MSG_W_DEFAULT
);

   logic [MSG_W-1:0] msgIn;
   logic [KEY_W-1:0] key;
   logic [KEY_W-1:0] n;
   logic             start;
   logic [MSG_W-1:0] msgOut;
   logic             fins;
`ifdef MOD_EXP_ERR_EN
   logic             err;

   modport master (output msgIn, key, n, start, input msgOut, fins, err);
   modport slave  (input msgIn, key, n, start, output msgOut, fins, err);
`else
   modport master (output msgIn, key, n, start, input msgOut, fins);
   modport slave  (input msgIn, key, n, start, output msgOut, fins);
`endif

endinterface

`default_nettype wire

// File: rtl/mod_mult.sv
// ============================================================================
// mod_mult : iterative shift-add modular multiplier, p = a*b mod n (b<n, n>=2)
// Revision : 1.0
// ============================================================================
`default_nettype none

module mod_mult #(
   parameter int W = 24
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic [W-1:0] a,
   input  wire logic [W-1:0] b,
   input  wire logic [W-1:0] n,
   input  wire logic         start,
   output logic      [W-1:0] p,
   output logic              done
);

   localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

   logic [W-1:0]     a_r;
   logic [W-1:0]     b_r;
   logic [W-1:0]     n_r;
   logic [W-1:0]     acc_r;
   logic [CNT_W-1:0] cnt_r;
   logic             busy_r;
   logic             done_r;

   logic [W+1:0]     dbl;
   logic [W+1:0]     dbl_red;
   logic [W+1:0]     sum;
   logic [W+1:0]     sum_red;
   logic [W-1:0]     acc_next;

   // acc < n is kept after each half-step, so one conditional subtract suffices
   always_comb begin
      dbl      = {1'b0, acc_r, 1'b0};
      dbl_red  = (dbl >= {2'b00, n_r}) ? dbl - {2'b00, n_r} : dbl;
      sum      = dbl_red + (a_r[W-1] ? {2'b00, b_r} : '0);
      sum_red  = (sum >= {2'b00, n_r}) ? sum - {2'b00, n_r} : sum;
      acc_next = W'(sum_red);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r    <= '0;
         b_r    <= '0;
         n_r    <= '0;
         acc_r  <= '0;
         cnt_r  <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else if (start) begin
         a_r    <= a;
         b_r    <= b;
         n_r    <= n;
         acc_r  <= '0;
         cnt_r  <= '0;
         busy_r <= 1'b1;
         done_r <= 1'b0;
      end else if (busy_r) begin
         acc_r <= acc_next;
         a_r   <= a_r << 1;
         cnt_r <= cnt_r + 1'b1;
         if (cnt_r == CNT_W'(W - 1)) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
         end
      end else begin
         done_r <= 1'b0;
      end
   end

   assign p    = acc_r;
   assign done = done_r;

endmodule

`default_nettype wire

// File: rtl/mod_exp.sv
// ============================================================================
// mod_exp  : msgOut = msgIn^key mod n, right-to-left square-and-multiply
// Revision : 1.0   (optional err output: define MOD_EXP_ERR_EN)
// ============================================================================
`default_nettype none

module mod_exp
   import mod_exp_pkg::*;
#(
   parameter int KEY_W = KEY_W_DEFAULT,
   parameter int MSG_W = MSG_W_DEFAULT
) (
   input  wire logic clk,
   input  wire logic rst,
   mod_exp_if.slave  bus
);

   state_t           state_r;
   state_t           state_next;
   logic [KEY_W-1:0] base_r;
   logic [KEY_W-1:0] exp_r;
   logic [KEY_W-1:0] n_r;
   logic [KEY_W-1:0] result_r;
   logic [MSG_W-1:0] msg_out_r;
   logic             issued_r;

   logic             mul_start;
   logic [KEY_W-1:0] mul_a;
   logic [KEY_W-1:0] mul_b;
   logic [KEY_W-1:0] mul_p;
   logic             mul_done;
   logic             n_small;

   assign n_small = (bus.n <= KEY_W'(1));

   mod_mult #(.W(KEY_W)) u_mult (
      .clk   (clk),
      .rst   (rst),
      .a     (mul_a),
      .b     (mul_b),
      .n     (n_r),
      .start (mul_start),
      .p     (mul_p),
      .done  (mul_done)
   );

   // Each multiply state issues one start pulse, then waits for done
   always_comb begin
      state_next = state_r;
      mul_start  = 1'b0;
      mul_a      = base_r;
      mul_b      = KEY_W'(1);
      case (state_r)
         IDLE: begin
            if (bus.start) state_next = n_small ? DONE : REDUCE;
         end
         REDUCE: begin
            mul_start = !issued_r;
            if (mul_done) state_next = CHECK;
         end
         CHECK: begin
            if (exp_r == '0)    state_next = DONE;
            else if (exp_r[0])  state_next = MUL;
            else                state_next = SQR;
         end
         MUL: begin
            mul_a     = result_r;
            mul_b     = base_r;
            mul_start = !issued_r;
            if (mul_done) state_next = SQR;
         end
         SQR: begin
            mul_b     = base_r;
            mul_start = !issued_r;
            if (mul_done) state_next = CHECK;
         end
         DONE: begin
            if (!bus.start) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         base_r    <= '0;
         exp_r     <= '0;
         n_r       <= '0;
         result_r  <= '0;
         msg_out_r <= '0;
         issued_r  <= 1'b0;
      end else begin
         state_r <= state_next;
         if (mul_start)     issued_r <= 1'b1;
         else if (mul_done) issued_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  base_r   <= KEY_W'(bus.msgIn);
                  exp_r    <= bus.key;
                  n_r      <= bus.n;
                  result_r <= n_small ? '0 : KEY_W'(1);
                  if (n_small) msg_out_r <= '0;
               end
            end
            REDUCE: if (mul_done) base_r <= mul_p;
            CHECK:  if (exp_r == '0) msg_out_r <= result_r[MSG_W-1:0];
            MUL:    if (mul_done) result_r <= mul_p;
            SQR: begin
               if (mul_done) begin
                  base_r <= mul_p;
                  exp_r  <= exp_r >> 1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.msgOut = msg_out_r;
   assign bus.fins   = (state_r == DONE);

`ifdef MOD_EXP_ERR_EN
   logic err_flag_r;
   logic err_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_flag_r <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         if (state_r == IDLE && bus.start) begin
            err_flag_r <= n_small || (KEY_W'(bus.msgIn) >= bus.n);
            err_r      <= n_small;
         end else if (state_r == CHECK && exp_r == '0) begin
            err_r <= err_flag_r;
         end else if (state_r == DONE && !bus.start) begin
            err_r <= 1'b0;
         end
      end
   end

   assign bus.err = err_r;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mod_exp.sv
// ============================================================================
// tb_mod_exp : directed self-checking bench for mod_exp
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_mod_exp;

   logic clk = 1'b0;
   logic rst;
   int   pass_cnt  = 0;
   int   check_cnt = 0;

   localparam int LIMIT = 2000;

   always #5 clk = ~clk;

   mod_exp_if bus ();

   mod_exp dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic wait_fins(output bit ok, output int cycles);
      ok     = 1'b0;
      cycles = 0;
      while (cycles < LIMIT) begin
         if (bus.fins === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic launch(input int m, input int k, input int nn);
      bus.msgIn = 12'(m);
      bus.key   = 24'(k);
      bus.n     = 24'(nn);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic drop_start();
      bus.start = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.msgIn = '0;
      bus.key   = '0;
      bus.n     = '0;
      repeat (3) @(posedge clk);
      #1;
      check_cnt++;
      if (bus.msgOut !== 12'd0) $display("FAIL reset_msgOut: got %0d want 0", bus.msgOut);
      else pass_cnt++;
      check_cnt++;
      if (bus.fins !== 1'b0) $display("FAIL reset_fins: got %b want 0", bus.fins);
      else pass_cnt++;
`ifdef MOD_EXP_ERR_EN
      check_cnt++;
      if (bus.err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err);
      else pass_cnt++;
`endif
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_hold_start();
      bit ok;
      int cyc;
      bit stable;
      launch(9, 7, 143);
      wait_fins(ok, cyc);
      check_cnt++;
      if (!ok) $display("FAIL hold_timeout: fins=%b after %0d cycles want 1", bus.fins, cyc);
      else pass_cnt++;
      check_cnt++;
      if (bus.msgOut !== 12'd48) $display("FAIL hold_result: got %0d want 48", bus.msgOut);
      else pass_cnt++;
      stable = 1'b1;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (bus.fins !== 1'b1 || bus.msgOut !== 12'd48) stable = 1'b0;
      end
      check_cnt++;
      if (!stable) $display("FAIL hold_stable: fins=%b msgOut=%0d want 1/48", bus.fins, bus.msgOut);
      else pass_cnt++;
      drop_start();
      check_cnt++;
      if (bus.fins !== 1'b0) $display("FAIL hold_drop: fins=%b want 0", bus.fins);
      else pass_cnt++;
   endtask

   task automatic test_small_modulus();
      int nv [2] = '{1, 0};
      for (int i = 0; i < 2; i++) begin
         launch(7, 5, nv[i]);
         if (bus.fins !== 1'b1) @(posedge clk);
         #1;
         check_cnt++;
         if (bus.fins !== 1'b1) $display("FAIL small_n%0d_fins: got %b want 1 within 2 cycles", nv[i], bus.fins);
         else pass_cnt++;
         check_cnt++;
         if (bus.msgOut !== 12'd0) $display("FAIL small_n%0d_result: got %0d want 0", nv[i], bus.msgOut);
         else pass_cnt++;
`ifdef MOD_EXP_ERR_EN
         check_cnt++;
         if (bus.err !== 1'b1) $display("FAIL small_n%0d_err: got %b want 1", nv[i], bus.err);
         else pass_cnt++;
`endif
         drop_start();
      end
   endtask

   task automatic test_vectors();
      int vm [6] = '{48, 200, 5, 4095, 3, 2};
      int vk [6] = '{103, 1, 0, 2, 16, 10};
      int vn [6] = '{143, 143, 143, 4093, 17, 1000};
      int ve [6] = '{9, 57, 1, 4, 1, 24};
      bit ok;
      int cyc;
      for (int i = 0; i < 6; i++) begin
         launch(vm[i], vk[i], vn[i]);
         wait_fins(ok, cyc);
         check_cnt++;
         if (!ok) $display("FAIL vec%0d_timeout: fins=%b after %0d cycles want 1", i, bus.fins, cyc);
         else pass_cnt++;
         check_cnt++;
         if (bus.msgOut !== 12'(ve[i]))
            $display("FAIL vec%0d_result: %0d^%0d mod %0d got %0d want %0d", i, vm[i], vk[i], vn[i], bus.msgOut, ve[i]);
         else pass_cnt++;
`ifdef MOD_EXP_ERR_EN
         check_cnt++;
         if (bus.err !== (vm[i] >= vn[i])) $display("FAIL vec%0d_err: got %b want %b", i, bus.err, vm[i] >= vn[i]);
         else pass_cnt++;
`endif
         drop_start();
         check_cnt++;
         if (bus.fins !== 1'b0) $display("FAIL vec%0d_drop: fins=%b want 0", i, bus.fins);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int cyc;
      launch(9, 24'hFFFFFF, 4093);
      repeat (100) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_cnt++;
      if (bus.fins !== 1'b0) $display("FAIL rstmid_fins: got %b want 0", bus.fins);
      else pass_cnt++;
      check_cnt++;
      if (bus.msgOut !== 12'd0) $display("FAIL rstmid_msgOut: got %0d want 0", bus.msgOut);
      else pass_cnt++;
      bus.msgIn = 12'd9;
      bus.key   = 24'd7;
      bus.n     = 24'd143;
      bus.start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      wait_fins(ok, cyc);
      check_cnt++;
      if (!ok) $display("FAIL rstmid_timeout: fins=%b after %0d cycles want 1", bus.fins, cyc);
      else pass_cnt++;
      check_cnt++;
      if (bus.msgOut !== 12'd48) $display("FAIL rstmid_result: got %0d want 48", bus.msgOut);
      else pass_cnt++;
      drop_start();
   endtask

   task automatic test_back_to_back();
      bit ok;
      int cyc;
      launch(5, 3, 143);
      repeat (5) @(posedge clk);
      #1;
      bus.msgIn = 12'd2;
      bus.key   = 24'd10;
      bus.n     = 24'd1000;
      wait_fins(ok, cyc);
      check_cnt++;
      if (!ok) $display("FAIL b2b_first_timeout: fins=%b after %0d cycles want 1", bus.fins, cyc);
      else pass_cnt++;
      check_cnt++;
      if (bus.msgOut !== 12'd125) $display("FAIL b2b_captured: got %0d want 125", bus.msgOut);
      else pass_cnt++;
      drop_start();
      check_cnt++;
      if (bus.fins !== 1'b0) $display("FAIL b2b_drop: fins=%b want 0", bus.fins);
      else pass_cnt++;
      launch(2, 10, 1000);
      wait_fins(ok, cyc);
      check_cnt++;
      if (!ok) $display("FAIL b2b_second_timeout: fins=%b after %0d cycles want 1", bus.fins, cyc);
      else pass_cnt++;
      check_cnt++;
      if (bus.msgOut !== 12'd24) $display("FAIL b2b_second: got %0d want 24", bus.msgOut);
      else pass_cnt++;
      drop_start();
   endtask

   initial begin
      test_reset();
      test_hold_start();
      test_small_modulus();
      test_vectors();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

`default_nettype wire
